// File: rtl/vga_pkg.sv
// vga_pkg: shared pixel colour type, sprite direction encoding and colour-cycle palette.
package vga_pkg;
  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb_t;
  // bit0 set: moving -x, bit1 set: moving -y
  typedef enum logic [1:0] {DR = 2'd0, DL = 2'd1, UR = 2'd2, UL = 2'd3} dir_t;
  localparam rgb_t PALETTE [8] = '{12'hF80, 12'h0F0, 12'h00F, 12'hFF0,
                                   12'h0FF, 12'hF0F, 12'hFFF, 12'h888};
endpackage

// File: rtl/vga_sync_delay.sv
// vga_sync_delay: enabled shift register delaying an active-low sync by DEPTH pixel enables.
module vga_sync_delay #(
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic d_i,
  output logic q_o
);
  logic [DEPTH-1:0] sr_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) sr_q <= '1;
    else if (en) sr_q <= {sr_q[DEPTH-2:0], d_i};
  assign q_o = sr_q[DEPTH-1];
endmodule

// File: rtl/vga_bounce_sprite.sv
// vga_bounce_sprite: draws a rectangle bouncing off the screen edges over a flat background.
// Define VGA_SPRITE_COLOR_CYCLE_EN to step the sprite colour through the palette on each bounce.
module vga_bounce_sprite
  import vga_pkg::*;
#(
  parameter int HPOS_WIDTH = 10,
  parameter int VPOS_WIDTH = 10,
  parameter int H_DISPLAY = 640,
  parameter int V_DISPLAY = 480,
  parameter int SPR_W = 32,
  parameter int SPR_H = 32,
  parameter int SPEED = 2,
  parameter int X_INIT = 0,
  parameter int Y_INIT = 0,
  parameter logic [11:0] SPR_RGB = 12'hF80,
  parameter logic [11:0] BG_RGB = 12'h008
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  pixel_clk,
  input  logic                  hsync_in,
  input  logic                  vsync_in,
  input  logic                  display_on,
  input  logic [HPOS_WIDTH-1:0] hpos,
  input  logic [VPOS_WIDTH-1:0] vpos,
  input  logic                  move_en,
  output logic                  hsync,
  output logic                  vsync,
  output logic [11:0]           rgb
);
  localparam int HW = HPOS_WIDTH + 1;
  localparam int VW = VPOS_WIDTH + 1;
  logic [HW-1:0] x_q, x_d, dx;
  logic [VW-1:0] y_q, y_d, dy;
  dir_t dir_q, dir_d;
  logic hit_q, disp_q, vs_prev_q, tick, flip_x, flip_y;
  rgb_t rgb_q, spr_col;
  // Offsets wrap to huge values left of / above the sprite, so one compare per axis suffices
  assign dx = {1'b0, hpos} - x_q;
  assign dy = {1'b0, vpos} - y_q;
  assign tick = pixel_clk & vs_prev_q & ~vsync_in;
  always_comb begin
    flip_x = dir_q[0] ? (x_q <= HW'(SPEED)) : (x_q + HW'(SPEED + SPR_W) >= HW'(H_DISPLAY));
    flip_y = dir_q[1] ? (y_q <= VW'(SPEED)) : (y_q + VW'(SPEED + SPR_H) >= VW'(V_DISPLAY));
    x_d = dir_q[0] ? (flip_x ? '0 : x_q - HW'(SPEED))
                   : (flip_x ? HW'(H_DISPLAY - SPR_W) : x_q + HW'(SPEED));
    y_d = dir_q[1] ? (flip_y ? '0 : y_q - VW'(SPEED))
                   : (flip_y ? VW'(V_DISPLAY - SPR_H) : y_q + VW'(SPEED));
    dir_d = dir_t'({dir_q[1] ^ flip_y, dir_q[0] ^ flip_x});
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      x_q <= HW'(X_INIT);
      y_q <= VW'(Y_INIT);
      dir_q <= DR;
      vs_prev_q <= 1'b1;
      hit_q <= 1'b0;
      disp_q <= 1'b0;
      rgb_q <= '0;
    end else if (pixel_clk) begin
      vs_prev_q <= vsync_in;
      hit_q <= (dx < HW'(SPR_W)) && (dy < VW'(SPR_H));
      disp_q <= display_on;
      rgb_q <= !disp_q ? '0 : hit_q ? spr_col : rgb_t'(BG_RGB);
      if (tick && move_en) begin
        x_q <= x_d;
        y_q <= y_d;
        dir_q <= dir_d;
      end
    end
`ifdef VGA_SPRITE_COLOR_CYCLE_EN
  logic [2:0] idx_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) idx_q <= '0;
    else if (tick && move_en && (flip_x || flip_y)) idx_q <= idx_q + 3'd1;
  assign spr_col = (idx_q == 3'd0) ? rgb_t'(SPR_RGB) : PALETTE[idx_q];
`else
  assign spr_col = rgb_t'(SPR_RGB);
`endif
  vga_sync_delay #(.DEPTH(2)) u_hs (.clk(clk), .rst(rst), .en(pixel_clk), .d_i(hsync_in), .q_o(hsync));
  vga_sync_delay #(.DEPTH(2)) u_vs (.clk(clk), .rst(rst), .en(pixel_clk), .d_i(vsync_in), .q_o(vsync));
  assign rgb = rgb_q;
endmodule

// File: tb/tb_vga_bounce_sprite.sv
// tb_vga_bounce_sprite: scoreboard bench for three sprite instances started at different positions.
module tb_vga_bounce_sprite;
  import vga_pkg::*;
  logic clk = 0, rst = 1, pixel_clk = 0, hsync_in = 1, vsync_in = 1, display_on = 0, move_en = 0;
  logic [9:0] hpos = '0, vpos = '0;
  logic hs0, vs0, hs1, vs1, hs2, vs2;
  logic [11:0] rgb0, rgb1, rgb2;
  int n = 0, errs = 0;
  typedef struct packed {logic [11:0] r0, r1, r2; logic hs, vs;} exp_t;
  exp_t sb[$];
  int mx[3], my[3], mdx[3], mdy[3], mi[3];
  bit prev_vs;
  localparam int X0 [3] = '{0, 607, 607};
  localparam int Y0 [3] = '{0, 100, 447};
`ifdef VGA_SPRITE_COLOR_CYCLE_EN
  localparam logic [11:0] C1 = PALETTE[1];
`else
  localparam logic [11:0] C1 = 12'hF80;
`endif
  always #5 clk = ~clk;

  vga_bounce_sprite u0 (.clk(clk), .rst(rst), .pixel_clk(pixel_clk), .hsync_in(hsync_in),
    .vsync_in(vsync_in), .display_on(display_on), .hpos(hpos), .vpos(vpos), .move_en(move_en),
    .hsync(hs0), .vsync(vs0), .rgb(rgb0));
  vga_bounce_sprite #(.X_INIT(607), .Y_INIT(100)) u1 (.clk(clk), .rst(rst), .pixel_clk(pixel_clk),
    .hsync_in(hsync_in), .vsync_in(vsync_in), .display_on(display_on), .hpos(hpos), .vpos(vpos),
    .move_en(move_en), .hsync(hs1), .vsync(vs1), .rgb(rgb1));
  vga_bounce_sprite #(.X_INIT(607), .Y_INIT(447)) u2 (.clk(clk), .rst(rst), .pixel_clk(pixel_clk),
    .hsync_in(hsync_in), .vsync_in(vsync_in), .display_on(display_on), .hpos(hpos), .vpos(vpos),
    .move_en(move_en), .hsync(hs2), .vsync(vs2), .rgb(rgb2));

  task automatic chk(input string tag, input logic [11:0] got, input logic [11:0] exp);
    n++;
    assert (got === exp) else begin
      errs++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      mx[i] = X0[i]; my[i] = Y0[i]; mdx[i] = 1; mdy[i] = 1; mi[i] = 0;
    end
    prev_vs = 1;
    sb.delete();
    sb.push_back('{12'h000, 12'h000, 12'h000, 1'b1, 1'b1});
  endtask

  function automatic logic [11:0] mrgb(int i, int h, int v, bit d);
    logic [11:0] col;
`ifdef VGA_SPRITE_COLOR_CYCLE_EN
    col = (mi[i] == 0) ? 12'hF80 : PALETTE[mi[i]];
`else
    col = 12'hF80;
`endif
    if (!d) return 12'h000;
    return (h >= mx[i] && h < mx[i] + 32 && v >= my[i] && v < my[i] + 32) ? col : 12'h008;
  endfunction

  task automatic step(input int i);
    bit b = 0;
    if (mdx[i] > 0) begin
      if (mx[i] + 34 >= 640) begin mx[i] = 608; mdx[i] = -1; b = 1; end else mx[i] += 2;
    end else if (mx[i] <= 2) begin mx[i] = 0; mdx[i] = 1; b = 1; end else mx[i] -= 2;
    if (mdy[i] > 0) begin
      if (my[i] + 34 >= 480) begin my[i] = 448; mdy[i] = -1; b = 1; end else my[i] += 2;
    end else if (my[i] <= 2) begin my[i] = 0; mdy[i] = 1; b = 1; end else my[i] -= 2;
    if (b) mi[i] = (mi[i] + 1) % 8;
  endtask

  task automatic check_exp(input string tag, input exp_t e);
    chk({tag, " rgb0"}, rgb0, e.r0);
    chk({tag, " rgb1"}, rgb1, e.r1);
    chk({tag, " rgb2"}, rgb2, e.r2);
    chk({tag, " hsync"}, {11'd0, hs0}, {11'd0, e.hs});
    chk({tag, " vsync"}, {11'd0, vs0}, {11'd0, e.vs});
    chk({tag, " sync1"}, {10'd0, hs1, vs1}, {10'd0, e.hs, e.vs});
    chk({tag, " sync2"}, {10'd0, hs2, vs2}, {10'd0, e.hs, e.vs});
  endtask

  task automatic pix(input int h, input int v, input bit d, input bit hs, input bit vs, input bit me);
    exp_t e;
    hpos = 10'(h); vpos = 10'(v); display_on = d; hsync_in = hs; vsync_in = vs; move_en = me;
    sb.push_back('{mrgb(0, h, v, d), mrgb(1, h, v, d), mrgb(2, h, v, d), hs, vs});
    if (prev_vs && !vs && me) for (int i = 0; i < 3; i++) step(i);
    prev_vs = vs;
    pixel_clk = 1;
    @(posedge clk);
    #1 pixel_clk = 0;
    e = sb.pop_front();
    check_exp("pix", e);
    @(posedge clk);
    #1 check_exp("hold", e);
  endtask

  task automatic frame(input bit me);
    pix(700, 500, 0, 1, 0, me);
    pix(700, 500, 0, 1, 1, me);
  endtask

  // Known-answer probe: pixel (h,v) reaches rgb after the following enable
  task automatic probe(input string tag, input int h, input int v, input bit d, input bit hs,
                       input logic [11:0] c0, input logic [11:0] c1, input logic [11:0] c2);
    pix(h, v, d, hs, 1, 1);
    pix(0, 0, 0, 1, 1, 1);
    chk({tag, " u0"}, rgb0, c0);
    chk({tag, " u1"}, rgb1, c1);
    chk({tag, " u2"}, rgb2, c2);
    chk({tag, " hs"}, {11'd0, hs0}, {11'd0, hs});
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset rgb", rgb0, 12'h000);
    chk("reset sync", {10'd0, hs0, vs0}, 12'h003);
    rst = 0;
    probe("T1 (0,0)", 0, 0, 1, 1, 12'hF80, 12'h008, 12'h008);
    probe("T1 (40,40)", 40, 40, 1, 1, 12'h008, 12'h008, 12'h008);
    probe("T1 (31,31)", 31, 31, 1, 1, 12'hF80, 12'h008, 12'h008);
    probe("T1 (32,0)", 32, 0, 1, 1, 12'h008, 12'h008, 12'h008);
    probe("T1 u1 init", 607, 100, 1, 1, 12'h008, 12'hF80, 12'h008);
    probe("T2 blank", 5, 5, 0, 0, 12'h000, 12'h000, 12'h000);
    pix(5, 5, 0, 0, 1, 1);
    pix(5, 5, 0, 1, 1, 1);
    pix(5, 5, 1, 1, 1, 1);
    frame(1);
    probe("T4 x608", 608, 105, 1, 1, 12'h008, C1, 12'h008);
    probe("T4 x607", 607, 105, 1, 1, 12'h008, 12'h008, 12'h008);
    probe("T5 corner", 608, 448, 1, 1, 12'h008, 12'h008, C1);
    probe("T5 y447", 608, 447, 1, 1, 12'h008, 12'h008, 12'h008);
    probe("T3 (2,2)", 2, 2, 1, 1, 12'hF80, 12'h008, 12'h008);
    probe("T3 (1,2)", 1, 2, 1, 1, 12'h008, 12'h008, 12'h008);
    frame(1);
    probe("T4 x606", 606, 110, 1, 1, 12'h008, C1, 12'h008);
    probe("T4 x605", 605, 110, 1, 1, 12'h008, 12'h008, 12'h008);
    probe("T5 UL", 606, 446, 1, 1, 12'h008, 12'h008, C1);
    frame(1);
    probe("T3 (6,6)", 6, 6, 1, 1, 12'hF80, 12'h008, 12'h008);
    probe("T3 (5,6)", 5, 6, 1, 1, 12'h008, 12'h008, 12'h008);
    probe("T3 (37,37)", 37, 37, 1, 1, 12'hF80, 12'h008, 12'h008);
    probe("T3 (38,37)", 38, 37, 1, 1, 12'h008, 12'h008, 12'h008);
    for (int f = 0; f < 5; f++) frame(0);
    probe("T6 (6,6)", 6, 6, 1, 1, 12'hF80, 12'h008, 12'h008);
    probe("T6 (5,6)", 5, 6, 1, 1, 12'h008, 12'h008, 12'h008);
    probe("T6 u1", 604, 106, 1, 1, 12'h008, C1, 12'h008);
    pix(10, 10, 1, 0, 1, 1);
    pix(10, 10, 1, 0, 1, 1);
    chk("T6 pre-rst rgb", rgb0, 12'hF80);
    chk("T6 pre-rst hs", {11'd0, hs0}, 12'h000);
    #2 rst = 1;
    #1;
    chk("T6 rst rgb0", rgb0, 12'h000);
    chk("T6 rst rgb12", {rgb1 | rgb2}, 12'h000);
    chk("T6 rst sync", {10'd0, hs0, vs0}, 12'h003);
    @(posedge clk);
    #1 rst = 0;
    model_reset();
    probe("post-rst (0,0)", 0, 0, 1, 1, 12'hF80, 12'h008, 12'h008);
    probe("post-rst init", 607, 447, 1, 1, 12'h008, 12'h008, 12'hF80);
    frame(1);
    probe("post-rst move", 608, 448, 1, 1, 12'h008, 12'h008, C1);
    $display("End of test - %0d assertions evaluated, %0d failures", n, errs);
    $finish;
  end
endmodule
